ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Receives PS/2 set-2 scan codes from an external keyboard and keeps the
//  88-bit held-note bitmap plus any-key flag that drive audio_codec keys/key_pressed.
//  Sits directly upstream of audio_codec, in the same iCLK_18_4 domain.
//  A fixed 12-key piano layout maps onto keys[base+0..base+11].
// PARAMETERS
//  FILTER_LEN      8      consecutive equal samples for a filtered PS/2 clock change
//  TIMEOUT_CYCLES  18432  max iCLK_18_4 cycles between PS/2 edges inside a frame (~1 ms)
//  NUM_KEYS        88     width of keys bitmap
// PORTS
//  iCLK_18_4     in   1         system clock, 18.432 MHz
//  iRST_N        in   1         async reset, active low
//  iPS2_CLK      in   1         raw PS/2 clock (async, open-drain, idle high)
//  iPS2_DAT      in   1         raw PS/2 data (async)
//  keys          out  NUM_KEYS  held-note bitmap, bit i = note i held
//  key_pressed   out  1         |keys, registered with keys
//  oScan_code    out  8         last accepted byte
//  oScan_valid   out  1         1-cycle pulse per accepted byte
//  oFrame_err    out  1         1-cycle pulse on parity/stop/timeout error
// BEHAVIOUR
//  Reset: keys=0, key_pressed=0, oScan_code=0, oScan_valid=0, oFrame_err=0, FSM=IDLE,
//   break/ext flags=0, octave=0; filtered clk=1. Reset mid-frame discards the frame.
//  Input: both pins through 2-FF sync; filtered clk changes only after FILTER_LEN equal
//   synced samples. Falling edge = filtered 1->0; data sampled on that cycle.
//  FSM (advances only on falling edge, except timeout):
//   IDLE: data=0 -> DATA, bitcnt=0; data=1 -> stay IDLE, no error.
//   DATA: shift in LSB first; after 8th bit -> PARITY.
//   PARITY: store bit -> STOP.
//   STOP: data=1 and odd parity over 8 data+parity bits -> accept; else error. -> IDLE.
//   Any non-IDLE state: TIMEOUT_CYCLES without edge -> IDLE, oFrame_err pulse.
//  Accept: cycle after stop edge: oScan_code=byte, oScan_valid=1, keys/key_pressed updated
//   in the same cycle. Error: oFrame_err=1, byte dropped, break/ext flags cleared.
//  Decode: F0 -> break=1; E0 -> ext=1; no key change. Other byte: if ext=0 and mapped,
//   make sets keys[base+idx], break clears it; then break=ext=0. E0-prefixed codes are
//   never notes. Unmapped codes and breaks of unheld keys ignored. Typematic repeat
//   make is idempotent. Multiple held keys independent.
//  Map idx0..11: 1C,1D,1B,24,23,2B,2C,34,35,33,3C,3B (A W S E D F T G Y H U J).
//  base = octave*12; bits >= base+12 never set by mapping; key_pressed = |keys.
// CONFIGURATION
//  PS2_OCTAVE_SHIFT_EN defined: make of 1A (Z) decrements octave, 22 (X) increments,
//   octave clamped 0..6 (no wrap); any change clears keys and key_pressed on the accept
//   cycle; Z/X breaks ignored. Not defined: octave fixed 0, 1A/22 treated as unmapped.
// TESTING
//  Frame 1C (parity 0), 5 us bit period -> oScan_valid, oScan_code=0x1C, keys[0]=1,
//   key_pressed=1.
//  Bytes F0,1C after key 0 held -> keys=0, key_pressed=0; oScan_valid pulses twice, no error.
//  1C,3B held; F0,1C -> keys[11]=1 only, key_pressed=1.
//  Frame 0x24 with parity bit flipped -> oFrame_err pulse, keys unchanged, no oScan_valid.
//  Stop after 4 data bits for >TIMEOUT_CYCLES -> oFrame_err, next full 0x23 frame sets keys[4].
//  E0,1C -> keys stay 0. Glitch of FILTER_LEN-1 low cycles on iPS2_CLK -> no bit shifted.
//  (EN) X,A -> keys[12]=1; X x7 -> octave 6; Z with key held -> keys cleared.
//  iRST_N low mid-frame -> all outputs 0; next frame decodes cleanly.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver that maintains an 88-note held-key bitmap for audio_codec.
// Optional octave shifting with Z/X is compiled in when PS2_OCTAVE_SHIFT_EN is defined.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 18432,
    parameter int NUM_KEYS       = 88
) (
    input  logic                iCLK_18_4,
    input  logic                iRST_N,
    input  logic                iPS2_CLK,
    input  logic                iPS2_DAT,
    output logic [NUM_KEYS-1:0] keys,
    output logic                key_pressed,
    output logic [7:0]          oScan_code,
    output logic                oScan_valid,
    output logic                oFrame_err,
    output logic [1:0]          o_dbg_state
);

    // oScan_valid and oFrame_err are single-cycle strobes with no backpressure;
    // oScan_code holds the last accepted byte until the next accept.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;
    logic [TW-1:0] r_tmo_cnt;
    state_t        r_state, w_state_next;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_brk, r_ext;
    logic [2:0]    r_oct;

    logic          w_filt_flip, w_fall, w_dat, w_timeout;
    logic          w_start, w_shift_en, w_par_en, w_accept, w_frame_err;
    logic [3:0]    w_idx;
    logic [6:0]    w_base, w_bit;
    logic [NUM_KEYS-1:0] w_keys_next;
    logic          w_brk_next, w_ext_next;
    logic [2:0]    w_oct_next;

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= iPS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= iPS2_DAT;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it.
    assign w_filt_flip = (r_clk_s2 != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall      = w_filt_flip && r_filt_clk;
    assign w_dat       = r_dat_s2;

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && !w_filt_flip &&
                       (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_accept     = 1'b0;
        w_frame_err  = 1'b0;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
            w_frame_err  = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_dat) begin
                        w_state_next = ST_DATA;
                        w_start      = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == 3'd7) w_state_next = ST_PARITY;
                end
                ST_PARITY: begin
                    w_par_en     = 1'b1;
                    w_state_next = ST_STOP;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    if (w_dat && (^{r_shift, r_par})) w_accept    = 1'b1;
                    else                              w_frame_err = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_start)         r_bitcnt <= '0;
            else if (w_shift_en) r_bitcnt <= r_bitcnt + 3'd1;
            if (w_shift_en) r_shift <= {w_dat, r_shift[7:1]};
            if (w_par_en)   r_par   <= w_dat;
            if (r_state == ST_IDLE || w_filt_flip) r_tmo_cnt <= '0;
            else                                   r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    function automatic logic [3:0] map_idx(input logic [7:0] code);
        case (code)
            8'h1C: map_idx = 4'd0;
            8'h1D: map_idx = 4'd1;
            8'h1B: map_idx = 4'd2;
            8'h24: map_idx = 4'd3;
            8'h23: map_idx = 4'd4;
            8'h2B: map_idx = 4'd5;
            8'h2C: map_idx = 4'd6;
            8'h34: map_idx = 4'd7;
            8'h35: map_idx = 4'd8;
            8'h33: map_idx = 4'd9;
            8'h3C: map_idx = 4'd10;
            8'h3B: map_idx = 4'd11;
            default: map_idx = 4'hF;
        endcase
    endfunction

    assign w_idx  = map_idx(r_shift);
    assign w_base = {4'd0, r_oct} * 7'd12;
    assign w_bit  = w_base + {3'd0, w_idx};

    always_comb begin
        w_keys_next = keys;
        w_brk_next  = r_brk;
        w_ext_next  = r_ext;
        w_oct_next  = r_oct;
        if (w_frame_err) begin
            w_brk_next = 1'b0;
            w_ext_next = 1'b0;
        end else if (w_accept) begin
            if (r_shift == 8'hF0) begin
                w_brk_next = 1'b1;
            end else if (r_shift == 8'hE0) begin
                w_ext_next = 1'b1;
            end else begin
                w_brk_next = 1'b0;
                w_ext_next = 1'b0;
                if (!r_ext) begin
`ifdef PS2_OCTAVE_SHIFT_EN
                    // Octave changes at the clamp limits are no-ops and leave held keys alone.
                    if (!r_brk && r_shift == 8'h1A) begin
                        if (r_oct != 3'd0) begin
                            w_oct_next  = r_oct - 3'd1;
                            w_keys_next = '0;
                        end
                    end else if (!r_brk && r_shift == 8'h22) begin
                        if (r_oct != 3'd6) begin
                            w_oct_next  = r_oct + 3'd1;
                            w_keys_next = '0;
                        end
                    end else
`endif
                    if (w_idx != 4'hF) w_keys_next[w_bit] = !r_brk;
                end
            end
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            keys        <= '0;
            key_pressed <= 1'b0;
            oScan_code  <= '0;
            oScan_valid <= 1'b0;
            oFrame_err  <= 1'b0;
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_oct       <= '0;
        end else begin
            keys        <= w_keys_next;
            key_pressed <= |w_keys_next;
            oScan_valid <= w_accept;
            oFrame_err  <= w_frame_err;
            if (w_accept) oScan_code <= r_shift;
            r_brk       <= w_brk_next;
            r_ext       <= w_ext_next;
            r_oct       <= w_oct_next;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed PS/2 frames plus random bytes,
// compared against a note-table reference model (octave tests when PS2_OCTAVE_SHIFT_EN is set).
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int TMO = 4000;
    localparam int NK  = 88;
`ifdef PS2_OCTAVE_SHIFT_EN
    localparam bit OCT_EN = 1'b1;
`else
    localparam bit OCT_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    always #27 clk = ~clk;

    logic [NK-1:0] keys;
    logic          key_pressed;
    logic [7:0]    scan_code;
    logic          scan_valid;
    logic          frame_err;
    logic [1:0]    dbg_state;

    ps2_key_decoder #(
        .FILTER_LEN(8),
        .TIMEOUT_CYCLES(TMO),
        .NUM_KEYS(NK)
    ) dut (
        .iCLK_18_4  (clk),
        .iRST_N     (rst_n),
        .iPS2_CLK   (ps2_clk),
        .iPS2_DAT   (ps2_dat),
        .keys       (keys),
        .key_pressed(key_pressed),
        .oScan_code (scan_code),
        .oScan_valid(scan_valid),
        .oFrame_err (frame_err),
        .o_dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    logic [7:0] last_code = 8'h00;

    // pulse monitor: counts every cycle a strobe is high
    always @(negedge clk) begin
        if (scan_valid) begin
            n_valid   = n_valid + 1;
            last_code = scan_code;
        end
        if (frame_err) n_ferr = n_ferr + 1;
    end

    // reference model
    logic [NK-1:0] m_keys;
    int            m_oct;
    bit            m_brk, m_ext;
    logic [7:0]    note_code [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                      8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};

    function automatic int note_idx(input logic [7:0] b);
        for (int i = 0; i < 12; i++) if (note_code[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_keys = '0;
        m_oct  = 0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
    endtask

    task automatic model_apply(input logic [7:0] b, input bit ok);
        int idx;
        if (!ok) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            if (!m_ext) begin
                if (OCT_EN && !m_brk && b == 8'h1A) begin
                    if (m_oct > 0) begin m_oct = m_oct - 1; m_keys = '0; end
                end else if (OCT_EN && !m_brk && b == 8'h22) begin
                    if (m_oct < 6) begin m_oct = m_oct + 1; m_keys = '0; end
                end else begin
                    idx = note_idx(b);
                    if (idx >= 0) m_keys[m_oct*12 + idx] = !m_brk;
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: device-side PS/2 waveform, 5 us bit period, data set while clock high
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            #1250;
            ps2_clk = 1'b0;
            #2500;
            ps2_clk = 1'b1;
            #1250;
        end
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b, input bit bad);
        int v0, e0;
        logic par;
        v0  = n_valid;
        e0  = n_ferr;
        par = ~(^b) ^ bad;
        send_bits({1'b1, par, b, 1'b0}, 11);
        #5000;
        model_apply(b, !bad);
        check({tag, "_valid"}, NK'(n_valid - v0), NK'(bad ? 0 : 1));
        check({tag, "_err"},   NK'(n_ferr - e0),  NK'(bad ? 1 : 0));
        if (!bad) check({tag, "_code"}, NK'(last_code), NK'(b));
        check({tag, "_keys"}, keys, m_keys);
        check({tag, "_kp"},   NK'(key_pressed), NK'(|m_keys));
    endtask

    logic [7:0] pool [20] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
                              8'h35, 8'h33, 8'h3C, 8'h3B, 8'hF0, 8'hF0, 8'hE0, 8'h1A,
                              8'h22, 8'h15, 8'h4D, 8'h76};

    initial begin
        int v0, e0;
        logic [7:0] b;
        bit bad;
        model_reset();

        // reset state
        repeat (10) @(negedge clk);
        check("rst_keys", keys, '0);
        check("rst_kp",   NK'(key_pressed), '0);
        check("rst_code", NK'(scan_code), '0);
        check("rst_valid", NK'(scan_valid), '0);
        check("rst_err",  NK'(frame_err), '0);
        check("rst_state", NK'(dbg_state), '0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // single make, then break
        frame_check("make_1c", 8'h1C, 1'b0);
        frame_check("brk_f0", 8'hF0, 1'b0);
        frame_check("brk_1c", 8'h1C, 1'b0);

        // two held keys, release one
        frame_check("two_1c", 8'h1C, 1'b0);
        frame_check("two_3b", 8'h3B, 1'b0);
        frame_check("two_f0", 8'hF0, 1'b0);
        frame_check("two_1c_brk", 8'h1C, 1'b0);

        // parity error
        frame_check("par_bad_24", 8'h24, 1'b1);

        // start + 4 data bits, then silence past the timeout
        v0 = n_valid;
        e0 = n_ferr;
        send_bits({1'b1, 1'b0, 8'h23, 1'b0}, 5);
        ps2_dat = 1'b1;
        repeat (TMO + 300) @(negedge clk);
        model_apply(8'h00, 1'b0);
        check("tmo_err",   NK'(n_ferr - e0),  NK'(1));
        check("tmo_valid", NK'(n_valid - v0), NK'(0));
        check("tmo_state", NK'(dbg_state), '0);
        check("tmo_keys",  keys, m_keys);
        frame_check("after_tmo_23", 8'h23, 1'b0);

        // clear held keys, then an E0-prefixed code must not become a note
        frame_check("clr_f0a", 8'hF0, 1'b0);
        frame_check("clr_3b",  8'h3B, 1'b0);
        frame_check("clr_f0b", 8'hF0, 1'b0);
        frame_check("clr_23",  8'h23, 1'b0);
        frame_check("ext_e0",  8'hE0, 1'b0);
        frame_check("ext_1c",  8'h1C, 1'b0);
        check("ext_keys_zero", keys, '0);

        // FILTER_LEN-1 cycle low glitch with data low must not start a frame
        @(negedge clk);
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (7) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        ps2_dat = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_state", NK'(dbg_state), '0);
        frame_check("glitch_1d", 8'h1D, 1'b0);
        frame_check("typematic_1d", 8'h1D, 1'b0);

        if (OCT_EN) begin
            frame_check("oct_x", 8'h22, 1'b0);
            frame_check("oct_a", 8'h1C, 1'b0);
            check("oct_key12", NK'(keys[12]), NK'(1));
            for (int i = 0; i < 6; i++) frame_check("oct_xn", 8'h22, 1'b0);
            frame_check("oct_clamp_x", 8'h22, 1'b0);
            frame_check("oct6_a", 8'h1C, 1'b0);
            check("oct_key72", NK'(keys[72]), NK'(1));
            frame_check("oct_z_clear", 8'h1A, 1'b0);
            check("oct_z_keys", keys, '0);
        end

        // randomized bytes against the model
        for (int i = 0; i < 20; i++) begin
            b   = pool[$urandom_range(0, 19)];
            bad = ($urandom_range(0, 7) == 0);
            frame_check("rand", b, bad);
        end

        // hold a key, then reset in the middle of a frame
        frame_check("pre_rst_1b", 8'h1B, 1'b0);
        send_bits({1'b1, 1'b0, 8'h2B, 1'b0}, 4);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        model_reset();
        check("mid_rst_keys",  keys, '0);
        check("mid_rst_kp",    NK'(key_pressed), '0);
        check("mid_rst_code",  NK'(scan_code), '0);
        check("mid_rst_valid", NK'(scan_valid), '0);
        check("mid_rst_err",   NK'(frame_err), '0);
        check("mid_rst_state", NK'(dbg_state), '0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        frame_check("post_rst_1c", 8'h1C, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
